// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the HI/LO multiply/divide control logic:
// funct codes, the mult/div sequencer state and the MD_Op encoding.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam int CNT_W = 6;

    // MD_Op is the low two funct bits of the mult/div instruction
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } md_state_t;

    // True for the four funct codes that occupy the mult/div unit
    function automatic logic is_muldiv(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_MULTU) ||
               (fn == FN_DIV)  || (fn == FN_DIVU);
    endfunction

    // True for funct codes that must wait for the mult/div unit to finish
    function automatic logic is_hilo_user(input logic [5:0] fn);
        return (fn == FN_MFHI) || (fn == FN_MTHI) ||
               (fn == FN_MFLO) || (fn == FN_MTLO) || is_muldiv(fn);
    endfunction

endpackage

// File: rtl/md_cycle_cnt.sv
// Loadable 6-bit down-counter that paces the iterative mult/div datapath.
// Load wins over decrement; the counter never wraps below zero.
module md_cycle_cnt
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: reload on start, otherwise step down while requested
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the iterative multiply/divide unit feeding HI/LO.
// Starts the datapath when a mult/div reaches EX, steps it for a fixed
// number of cycles, commits HI/LO, and stalls ID while results are pending.
// Stall outputs are active-low to match the load-use hazard unit.
module muldiv_ctrl
    import mips_pkg::*;
#(
    parameter int MUL_CYCLES = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] EX_Opcode,
    input  logic [5:0] EX_Funct,
    input  logic       EX_Valid,
    input  logic       Flush,
    input  logic       DivZero,
    input  logic [5:0] ID_Opcode,
    input  logic [5:0] ID_Funct,
    output logic       MD_Start,
    output logic [1:0] MD_Op,
    output logic       MD_Step,
    output logic       HiLoWrite,
    output logic       Busy,
    output logic       Hazard,
    output logic       PCWrite,
    output logic       IRWrite
);

    // Counter preload is N-1 so that BUSY lasts exactly N cycles
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_t state_q;
    md_op_t    op_q;
    logic      zflag_q;
    logic      busy_q;
    logic      step_q;
    logic      hilo_q;

    logic      start;
    logic      start_div;
    logic      id_dep;
    logic      stall;
    logic      cnt_load;
    logic      cnt_dec;
    logic      cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;

    assign start = EX_Valid && !Flush && (EX_Opcode == OP_RTYPE) &&
                   is_muldiv(EX_Funct) && (state_q == IDLE);

    // DIV/DIVU are the two codes with funct[1] set
    assign start_div    = EX_Funct[1];
    assign cnt_load     = start && !(start_div && DivZero);
    assign cnt_load_val = start_div ? DIV_LOAD : MUL_LOAD;
    assign cnt_dec      = (state_q == BUSY) && !cnt_zero;

    md_cycle_cnt u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Sequencer FSM with registered step/commit/busy outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= MD_MULT;
            zflag_q <= 1'b0;
            busy_q  <= 1'b0;
            step_q  <= 1'b0;
            hilo_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q   <= md_op_t'(EX_Funct[1:0]);
                        busy_q <= 1'b1;
                        hilo_q <= 1'b0;
                        if (start_div && DivZero) begin
                            // Divide by zero skips the iterations and HI/LO write
                            state_q <= DONE;
                            zflag_q <= 1'b1;
                            step_q  <= 1'b0;
                        end else begin
                            state_q <= BUSY;
                            zflag_q <= 1'b0;
                            step_q  <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_zero) begin
                        state_q <= DONE;
                        step_q  <= 1'b0;
                        hilo_q  <= !zflag_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    hilo_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    step_q  <= 1'b0;
                    hilo_q  <= 1'b0;
                end
            endcase
        end
    end

    // ID must wait whenever the unit is occupied or being started this cycle
    assign id_dep = (ID_Opcode == OP_RTYPE) && is_hilo_user(ID_Funct);
    assign stall  = id_dep && (busy_q || start);

    assign MD_Start  = start;
    assign MD_Op     = op_q;
    assign MD_Step   = step_q;
    assign HiLoWrite = hilo_q;
    assign Busy      = busy_q;
    assign Hazard    = !stall;
    assign PCWrite   = !stall;
    assign IRWrite   = !stall;

endmodule
